// File: rtl/optflow_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// optflow_pkg : shared types, scaling constants and saturation helper
// Rev 1.0
// ----------------------------------------------------------------------------
package optflow_pkg;

  typedef enum logic {
    GRAD_SOBEL = 1'b0,
    GRAD_CDIFF = 1'b1
  } grad_mode_e;

  localparam int SOBEL_SHIFT = 3;
  localparam int CDIFF_SHIFT = 1;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int                 w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_signed = hi;
    end else if (v < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = v;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_3x3.sv
`default_nettype none
// ----------------------------------------------------------------------------
// window_3x3 : two line delays plus a 3x3 tap register, advanced by en_i
// Rev 1.0
// ----------------------------------------------------------------------------
module window_3x3 #(
  parameter int IMG_WIDTH   = 320,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                en_i,
  input  logic [PIXEL_WIDTH-1:0]              pixel_i,
  output logic [2:0][2:0][PIXEL_WIDTH-1:0]    win_o
);

  logic [PIXEL_WIDTH-1:0]           line1_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0]           line2_q [IMG_WIDTH];
  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q;

  // Row 2 is the newest line, column 2 the newest pixel.
  always_ff @(posedge clk) begin
    if (en_i) begin
      line1_q[0] <= pixel_i;
      line2_q[0] <= line1_q[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        line1_q[i] <= line1_q[i-1];
        line2_q[i] <= line2_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[2][2] <= pixel_i;
      win_q[1][2] <= line1_q[IMG_WIDTH-1];
      win_q[0][2] <= line2_q[IMG_WIDTH-1];
    end
  end

  assign win_o = win_q;

endmodule
`default_nettype wire

// File: rtl/gradient_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gradient_pipe : streaming Ix/Iy/It with per-frame Sobel or central difference
// Rev 1.0
// ----------------------------------------------------------------------------
module gradient_pipe
  import optflow_pkg::*;
#(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int PIXEL_WIDTH = 8,
  parameter int GRAD_WIDTH  = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [PIXEL_WIDTH-1:0]       pixel_curr,
  input  logic [PIXEL_WIDTH-1:0]       pixel_prev,
  input  logic                         mode,
  output logic signed [GRAD_WIDTH-1:0] grad_x,
  output logic signed [GRAD_WIDTH-1:0] grad_y,
  output logic signed [GRAD_WIDTH-1:0] grad_t,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sof,
  output logic                         out_eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int SW = PIXEL_WIDTH + 2;
  localparam int AW = PIXEL_WIDTH + 4;
  localparam int DW = PIXEL_WIDTH + 1;

  typedef struct packed {
    logic signed [GRAD_WIDTH-1:0] x;
    logic signed [GRAD_WIDTH-1:0] y;
    logic signed [GRAD_WIDTH-1:0] t;
  } grad_triple_t;

  function automatic logic [SW-1:0] wsum(input logic [PIXEL_WIDTH-1:0] a,
                                         input logic [PIXEL_WIDTH-1:0] b,
                                         input logic [PIXEL_WIDTH-1:0] c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  logic stall, advance, accept;
  logic out_valid_q, out_sof_q, out_eof_q;
  grad_triple_t grad_q;

  assign stall    = out_valid_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Raster position of the pixel on the input this cycle.
  logic [XW-1:0] x_q, x_d, cx;
  logic [YW-1:0] y_q, y_d, cy;
  grad_mode_e    mode_q, cur_mode;
  logic          interior, at_sof, at_eof;

  always_comb begin
    cx       = in_sof ? '0 : x_q;
    cy       = in_sof ? '0 : y_q;
    cur_mode = in_sof ? grad_mode_e'(mode) : mode_q;
    interior = (cx >= XW'(2)) && (cy >= YW'(2));
    at_sof   = (cx == XW'(2)) && (cy == YW'(2));
    at_eof   = (cx == XW'(IMG_WIDTH - 1)) && (cy == YW'(IMG_HEIGHT - 1));
    x_d      = x_q;
    y_d      = y_q;
    if (accept) begin
      if (cx == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        y_d = (cy == YW'(IMG_HEIGHT - 1)) ? '0 : cy + 1'b1;
      end else begin
        x_d = cx + 1'b1;
        y_d = cy;
      end
    end
  end

  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_curr, win_prev;

  window_3x3 #(.IMG_WIDTH(IMG_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)) u_win_curr (
    .clk     (clk),
    .en_i    (accept),
    .pixel_i (pixel_curr),
    .win_o   (win_curr)
  );

  window_3x3 #(.IMG_WIDTH(IMG_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)) u_win_prev (
    .clk     (clk),
    .en_i    (accept),
    .pixel_i (pixel_prev),
    .win_o   (win_prev)
  );

  logic [2:0][2:0][PIXEL_WIDTH-1:0] w_avg;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign w_avg[r][c] =
        PIXEL_WIDTH'(({1'b0, win_curr[r][c]} + {1'b0, win_prev[r][c]}) >> 1);
    end
  end

  // Sideband travels with the data: window stage (0), S1, S2.
  logic       v0_q, v1_q, v2_q;
  logic       sof0_q, sof1_q, sof2_q;
  logic       eof0_q, eof1_q, eof2_q;
  grad_mode_e mode0_q, mode1_q, mode2_q;

  logic [2:0][2:0][PIXEL_WIDTH-1:0] avg1_q;
  logic [PIXEL_WIDTH-1:0]           cc1_q, pc1_q;

  logic [SW-1:0]        coll2_q, colr2_q, rowt2_q, rowb2_q;
  logic signed [DW-1:0] cdx2_q, cdy2_q, dt2_q;

  always_ff @(posedge clk) begin
    if (advance) begin
      sof0_q  <= at_sof;
      eof0_q  <= at_eof;
      mode0_q <= cur_mode;

      avg1_q  <= w_avg;
      cc1_q   <= win_curr[1][1];
      pc1_q   <= win_prev[1][1];
      sof1_q  <= sof0_q;
      eof1_q  <= eof0_q;
      mode1_q <= mode0_q;

      coll2_q <= wsum(avg1_q[0][0], avg1_q[1][0], avg1_q[2][0]);
      colr2_q <= wsum(avg1_q[0][2], avg1_q[1][2], avg1_q[2][2]);
      rowt2_q <= wsum(avg1_q[0][0], avg1_q[0][1], avg1_q[0][2]);
      rowb2_q <= wsum(avg1_q[2][0], avg1_q[2][1], avg1_q[2][2]);
      cdx2_q  <= $signed({1'b0, avg1_q[1][2]}) - $signed({1'b0, avg1_q[1][0]});
      cdy2_q  <= $signed({1'b0, avg1_q[2][1]}) - $signed({1'b0, avg1_q[0][1]});
      dt2_q   <= $signed({1'b0, pc1_q}) - $signed({1'b0, cc1_q});
      sof2_q  <= sof1_q;
      eof2_q  <= eof1_q;
      mode2_q <= mode1_q;
    end
  end

  logic signed [AW-1:0] acc_x, acc_y;
  logic signed [31:0]   w_gx, w_gy, w_gt;
  grad_triple_t         w_grad;

  always_comb begin
    acc_x = $signed({2'b00, colr2_q}) - $signed({2'b00, coll2_q});
    acc_y = $signed({2'b00, rowb2_q}) - $signed({2'b00, rowt2_q});
    if (mode2_q == GRAD_CDIFF) begin
      w_gx = 32'(cdx2_q) >>> CDIFF_SHIFT;
      w_gy = 32'(cdy2_q) >>> CDIFF_SHIFT;
    end else begin
      w_gx = 32'(acc_x) >>> SOBEL_SHIFT;
      w_gy = 32'(acc_y) >>> SOBEL_SHIFT;
    end
    w_gt     = 32'(dt2_q);
    w_grad.x = GRAD_WIDTH'(sat_signed(w_gx, GRAD_WIDTH));
    w_grad.y = GRAD_WIDTH'(sat_signed(w_gy, GRAD_WIDTH));
    w_grad.t = GRAD_WIDTH'(sat_signed(w_gt, GRAD_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= GRAD_SOBEL;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      grad_q      <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (accept && in_sof) begin
        mode_q <= grad_mode_e'(mode);
      end
      if (advance) begin
        v0_q        <= accept && interior;
        v1_q        <= v0_q;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        out_sof_q   <= v2_q && sof2_q;
        out_eof_q   <= v2_q && eof2_q;
        if (v2_q) begin
          grad_q <= w_grad;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign grad_x    = grad_q.x;
  assign grad_y    = grad_q.y;
  assign grad_t    = grad_q.t;

endmodule
`default_nettype wire

// File: tb/tb_gradient_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gradient_pipe : scoreboard bench for gradient_pipe on a small 8x6 frame
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gradient_pipe;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int GW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_sof, out_eof;
  logic [PW-1:0] pixel_curr = '0, pixel_prev = '0;
  logic signed [GW-1:0] grad_x, grad_y, grad_t;

  gradient_pipe #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW), .GRAD_WIDTH(GW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .pixel_curr (pixel_curr),
    .pixel_prev (pixel_prev),
    .mode       (mode),
    .grad_x     (grad_x),
    .grad_y     (grad_y),
    .grad_t     (grad_t),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof)
  );

  typedef struct {
    int gx;
    int gy;
    int gt;
    int sof;
    int eof;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   out_cnt = 0;
  bit   mon_en  = 1'b0;
  bit   stall_rand = 1'b0;
  bit   gap_rand   = 1'b0;
  int   img_c [H][W];
  int   img_p [H][W];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 << (GW - 1)) - 1;
    lo = -(1 << (GW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int avg(input int y, input int x);
    return (img_c[y][x] + img_p[y][x]) / 2;
  endfunction

  // kind: 0 ramp x, 1 ramp y, 2 flat a/b, 3 step 0|255, 4 step 255|0, else random
  task automatic fill(input int kind, input int a, input int b);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0: begin img_c[y][x] = x; img_p[y][x] = x; end
          1: begin img_c[y][x] = y; img_p[y][x] = y; end
          2: begin img_c[y][x] = a; img_p[y][x] = b; end
          3: begin img_c[y][x] = (x < W/2) ? 0 : 255; img_p[y][x] = img_c[y][x]; end
          4: begin img_c[y][x] = (x < W/2) ? 255 : 0; img_p[y][x] = img_c[y][x]; end
          default: begin
            img_c[y][x] = int'($urandom_range(0, 255));
            img_p[y][x] = int'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  // Expected outputs for the first npix raster pixels of the current images.
  task automatic model_frame(input bit m, input int npix);
    int x, y, cx, cy, sx, sy;
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      x = k % W;
      y = k / W;
      if (x >= 2 && y >= 2) begin
        cx = x - 1;
        cy = y - 1;
        if (!m) begin
          sx = (avg(cy-1, cx+1) + 2*avg(cy, cx+1) + avg(cy+1, cx+1))
             - (avg(cy-1, cx-1) + 2*avg(cy, cx-1) + avg(cy+1, cx-1));
          sy = (avg(cy+1, cx-1) + 2*avg(cy+1, cx) + avg(cy+1, cx+1))
             - (avg(cy-1, cx-1) + 2*avg(cy-1, cx) + avg(cy-1, cx+1));
          e.gx = sat(fdiv(sx, 8));
          e.gy = sat(fdiv(sy, 8));
        end else begin
          e.gx = sat(fdiv(avg(cy, cx+1) - avg(cy, cx-1), 2));
          e.gy = sat(fdiv(avg(cy+1, cx) - avg(cy-1, cx), 2));
        end
        e.gt  = sat(img_p[cy][cx] - img_c[cy][cx]);
        e.sof = (cx == 1 && cy == 1) ? 1 : 0;
        e.eof = (cx == W-2 && cy == H-2) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_pixel();
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 1000) begin
        $display("FAIL accept_timeout: got no accept expected accept within 1000 cycles");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Mode is randomised on non-sof pixels; only the sof value may take effect.
  task automatic drive_frame(input bit m, input int npix);
    for (int k = 0; k < npix; k++) begin
      if (gap_rand && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_sof     = (k == 0);
      mode       = (k == 0) ? m : 1'($urandom_range(0, 1));
      pixel_curr = PW'(img_c[k / W][k % W]);
      pixel_prev = PW'(img_p[k / W][k % W]);
      send_pixel();
    end
  endtask

  task automatic run_frame(input int kind, input int a, input int b, input bit m);
    fill(kind, a, b);
    model_frame(m, W * H);
    drive_frame(m, W * H);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    out_ready = stall_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: pops and compares on every output handshake.
  initial begin
    bit   prev_stall;
    int   held;
    exp_t e;
    prev_stall = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          chk("stall_hold", int'({out_valid, out_sof, out_eof, grad_x, grad_y, grad_t}), held);
        end
        prev_stall = out_valid && !out_ready;
        held = int'({out_valid, out_sof, out_eof, grad_x, grad_y, grad_t});
        if (out_valid && out_ready && mon_en) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("grad_x", int'(grad_x), e.gx);
            chk("grad_y", int'(grad_y), e.gy);
            chk("grad_t", int'(grad_t), e.gt);
            chk("out_sof", int'(out_sof), e.sof);
            chk("out_eof", int'(out_eof), e.eof);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    bit m;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_grad_x", int'(grad_x), 0);
    chk("rst_grad_y", int'(grad_y), 0);
    chk("rst_grad_t", int'(grad_t), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    c0 = out_cnt;
    run_frame(0, 0, 0, 1'b0);
    drain();
    chk("ramp_count", out_cnt - c0, (W - 2) * (H - 2));

    run_frame(0, 0, 0, 1'b1);
    run_frame(1, 0, 0, 1'b0);
    run_frame(2, 100, 90, 1'b0);
    run_frame(2, 90, 100, 1'b1);
    run_frame(3, 0, 0, 1'b0);
    run_frame(4, 0, 0, 1'b0);
    run_frame(3, 0, 0, 1'b1);
    drain();

    stall_rand = 1'b1;
    gap_rand   = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(5, 0, 0, 1'($urandom_range(0, 1)));
    end
    // Abandoned frame followed by an in_sof restart.
    fill(5, 0, 0);
    m = 1'($urandom_range(0, 1));
    model_frame(m, 20);
    drive_frame(m, 20);
    run_frame(5, 0, 0, 1'($urandom_range(0, 1)));
    run_frame(0, 0, 0, 1'b0);
    drain();

    stall_rand = 1'b0;
    gap_rand   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    fill(5, 0, 0);
    drive_frame(1'b0, 3 * W + 6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    c0 = out_cnt;
    run_frame(5, 0, 0, 1'($urandom_range(0, 1)));
    drain();
    chk("post_rst_count", out_cnt - c0, (W - 2) * (H - 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gradient_pipe.md
Name: gradient_pipe

Overview:
- Parametrised, fully pipelined successor of the spatial/temporal gradient stage.
- Accepts paired current/previous-frame pixels over a ready/valid stream and builds 3x3 windows internally for both frames.
- Emits saturated signed Ix, Iy, It per interior pixel, with a per-frame selectable operator (Sobel or central difference).
- Sits between the frame-pair source and the structure-tensor accumulator.

Parameters:
- IMG_WIDTH, 320, pixels per line (>=4)
- IMG_HEIGHT, 240, lines per frame (>=4)
- PIXEL_WIDTH, 8, unsigned pixel width
- GRAD_WIDTH, 12, signed output gradient width (>=4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pixel pair valid
- in_ready  out  1  block can accept a pair this cycle
- in_sof  in  1  qualifies the first pixel of a frame
- pixel_curr  in  PIXEL_WIDTH  current-frame pixel
- pixel_prev  in  PIXEL_WIDTH  previous-frame pixel
- mode  in  1  0 = Sobel/8, 1 = central difference/2; captured on the accepted sof pixel
- grad_x  out  GRAD_WIDTH  Ix
- grad_y  out  GRAD_WIDTH  Iy
- grad_t  out  GRAD_WIDTH  It
- out_valid  out  1  gradient triple valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  first gradient of a frame
- out_eof  out  1  last gradient of a frame

Behaviour:
- Reset values: out_valid=0, grad_*=0, out_sof=0, out_eof=0, x/y counters=0, mode register=0. in_ready=1 in the cycle after reset.
- Accept rule: a pixel is accepted when in_valid && in_ready. Window shift and x/y counters advance only on accept.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - When stall is high, all pipeline registers hold and outputs stay stable.
  - No data is lost or duplicated.
- Raster order: x counts 0..IMG_WIDTH-1, then wraps to 0 and y increments. After (W-1,H-1), counters wrap to (0,0).
- Frame restart: an accepted in_sof forces the current pixel to (0,0), even mid-frame. Stale line-buffer rows are masked by the y gate below.
- Window centre: accepting pixel (x,y) with x>=2 and y>=2 forms the window centred on (x-1,y-1). Only interior pixels produce output, giving (W-2)*(H-2) outputs per frame.
- Pipeline (3 stages, latency 3 accepted-cycles, no stall):
  - S1: avg = (curr+prev)>>1, floor, per window tap, for both frames.
  - S2: row/column partial sums.
  - S3: combine, scale, saturate.
- Sobel (mode=0):
  - accX = sum of right column (weights 1,2,1) minus left column (1,2,1); accY is the same on bottom/top rows.
  - Output = acc>>>3 (arithmetic, floor).
  - Accumulator width PIXEL_WIDTH+4 signed.
- Central difference (mode=1): Ix=(avg[1][2]-avg[1][0])>>>1, Iy=(avg[2][1]-avg[0][1])>>>1.
- It = prev_centre - curr_centre (raw, not averaged).
- Saturation: all three outputs saturate to [-2^(GRAD_WIDTH-1), 2^(GRAD_WIDTH-1)-1]. They never wrap.
- Frame flags: out_sof on output for centre (1,1); out_eof on centre (W-2,H-2).
- Mode latching: mode is latched at the accepted sof. A change mid-frame takes effect at the next sof only.
- Reset mid-operation: reset flushes the pipeline (out_valid=0 next cycle) and clears the counters. No output appears until a new window reaches x>=2, y>=2.

Decomposition:
- optflow_pkg:
  - grad_mode_e {GRAD_SOBEL, GRAD_CDIFF}
  - SOBEL_SHIFT=3, CDIFF_SHIFT=1
  - sat_signed function
  - gradient triple struct type, parametrised via GRAD_WIDTH localparam in the module
- Sub-module window_3x3:
  - Two line FIFOs of depth IMG_WIDTH plus a 3x3 shift register, gated by an enable.
  - Instantiated twice (curr, prev); the enable is the accept condition.

Test Plan:
- Horizontal ramp p(x,y)=x, curr=prev, W=8, H=6, mode=0 -> exactly 24 outputs, all Ix=1, Iy=0, It=0; out_sof on first, out_eof on 24th.
- Same ramp, mode=1 -> all Ix=1, Iy=0, It=0; then vertical ramp p=y, mode=0 -> Iy=1, Ix=0.
- Flat frames, curr=100, prev=90 -> It=-10, Ix=Iy=0 for every output; swapped -> It=+10.
- GRAD_WIDTH=6, vertical step 0|255, mode=0 -> edge Ix saturates to +31 (unsaturated 127); mirrored step -> -32; no wrap.
- Random out_ready (50% low), random in_valid gaps -> output sequence is bit-identical to the unstalled run; in_ready low exactly when out_valid && !out_ready.
- Reset asserted mid-frame at pixel (5,3), then new frame with in_sof -> out_valid=0 the cycle after reset; first output corresponds to centre (1,1) of the new frame, 3 accepted cycles after pixel (2,2).
